// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle for the unified memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data has priority; a lost-arbitration counter guarantees fetch progress.
//
//   state  | meaning
//   IDLE   | no transaction outstanding, arbitrating
//   BUSY_I | fetch read in flight, waiting for mem_ready
//   BUSY_D | data load/store in flight, waiting for mem_ready
module mem_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                halt,
  output logic                proto_err,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              proto_err_q, proto_err_d;
  logic              elig_i, elig_d;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  // A requester whose ack is visible this cycle has not yet dropped req.
  assign elig_i = bus.i_req & ~halt & ~i_ack_q;
  assign elig_d = bus.d_req & ~d_ack_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    proto_err_d = proto_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_ready) proto_err_d = 1'b1;
        if (elig_i && (!elig_d || wait_q == MAX_W)) begin
          state_d     = BUSY_I;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
        end else if (elig_d) begin
          state_d     = BUSY_D;
          if (elig_i && wait_q < MAX_W) wait_d = wait_q + 4'd1;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = bus.mem_rdata;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign proto_err     = proto_err_q;

endmodule
